// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg: sequencer state encoding and the default systolic pipeline latency.
package tpu_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        POP    = 3'd2,
        RELOAD = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_t;
    localparam int ARRAY_DEPTH = 128;
    localparam int UB_RD_LAT = 1;
    // Skew in plus deskew out across the array, plus the UB read.
    localparam int PIPE_LAT_DEF = ARRAY_DEPTH * 2 + UB_RD_LAT;
endpackage

// File: rtl/tpu_run_sequencer_if.sv
// tpu_run_sequencer_if: run-control pins between the host/datapath and the sequencer.
interface tpu_run_sequencer_if #(parameter int ADDRESSSIZE = 10);
    logic start, abort, fifo_empty;
    logic fifo_read_enable, we_rl, ub_valid, res_write_enable, busy, done, err;
    logic [ADDRESSSIZE-1:0] num_rows, ub_base, res_base, ub_address, res_address;
    modport master (
        output start, abort, num_rows, ub_base, res_base, fifo_empty,
        input fifo_read_enable, we_rl, ub_address, ub_valid, res_write_enable, res_address, busy, done, err
    );
    modport slave (
        input start, abort, num_rows, ub_base, res_base, fifo_empty,
        output fifo_read_enable, we_rl, ub_address, ub_valid, res_write_enable, res_address, busy, done, err
    );
endinterface

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: base-plus-offset address counter; clr loads base, en steps by one with modulo wrap.
module seq_addr_gen #(parameter int W = 10) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] base,
    output logic [W-1:0] addr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) addr <= '0;
        else if (clr) addr <= base;
        else if (en) addr <= addr + 1'b1;
endmodule

// File: rtl/tpu_run_sequencer.sv
// tpu_run_sequencer: sequences one matmul pass - weight pop, reload, UB row stream, result writes.
module tpu_run_sequencer import tpu_ctrl_pkg::*; #(
    parameter int ADDRESSSIZE = 10,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int CNT_W = 12
) (
    input logic clk,
    input logic rst,
    tpu_run_sequencer_if.slave bus
);
    state_t state;
    logic [ADDRESSSIZE-1:0] rows, ub_b, res_b, ub_addr, res_addr;
    logic [CNT_W-1:0] cnt, nxt, last;
    logic ub_v, res_we, fre, rl, dn, er, busy_q, stream_end, win_nxt;
    assign nxt = cnt + 1'b1;
    assign last = CNT_W'(PIPE_LAT) + CNT_W'(rows) - 1'b1;
    assign stream_end = nxt == CNT_W'(rows);
    // Outputs are registered, so the write window is evaluated for the cycle being entered.
    assign win_nxt = nxt >= CNT_W'(PIPE_LAT) && nxt <= last;
    seq_addr_gen #(.W(ADDRESSSIZE)) u_ub (
        .clk(clk), .rst(rst), .clr(state == RELOAD), .en(ub_v), .base(ub_b), .addr(ub_addr)
    );
    seq_addr_gen #(.W(ADDRESSSIZE)) u_res (
        .clk(clk), .rst(rst), .clr(state == RELOAD), .en(res_we), .base(res_b), .addr(res_addr)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            rows <= '0;
            ub_b <= '0;
            res_b <= '0;
            cnt <= '0;
            {ub_v, res_we, fre, rl, dn, er, busy_q} <= '0;
        end else begin
            {fre, rl, dn, er} <= '0;
            if (state != IDLE && bus.abort) begin
                state <= IDLE;
                {ub_v, res_we, busy_q} <= '0;
            end else
                case (state)
                    IDLE: if (bus.start) begin
                        if (bus.num_rows == '0) er <= 1'b1;
                        else begin
                            rows <= bus.num_rows;
                            ub_b <= bus.ub_base;
                            res_b <= bus.res_base;
                            busy_q <= 1'b1;
                            state <= WAIT_W;
                        end
                    end
                    WAIT_W: if (!bus.fifo_empty) begin
                        fre <= 1'b1;
                        state <= POP;
                    end
                    POP: begin
                        rl <= 1'b1;
                        state <= RELOAD;
                    end
                    RELOAD: begin
                        cnt <= '0;
                        ub_v <= 1'b1;
                        state <= STREAM;
                    end
                    STREAM: begin
                        cnt <= nxt;
                        ub_v <= !stream_end;
                        res_we <= win_nxt;
                        if (stream_end) state <= DRAIN;
                    end
                    DRAIN: if (cnt == last) begin
                        res_we <= 1'b0;
                        dn <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= nxt;
                        res_we <= win_nxt;
                    end
                    DONE: begin
                        busy_q <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
    assign bus.fifo_read_enable = fre;
    assign bus.we_rl = rl;
    assign bus.ub_address = ub_addr;
    assign bus.ub_valid = ub_v;
    assign bus.res_write_enable = res_we;
    assign bus.res_address = res_addr;
    assign bus.busy = busy_q;
    assign bus.done = dn;
    assign bus.err = er;
endmodule

// File: tb/tb_tpu_run_sequencer.sv
// tb_tpu_run_sequencer: two sequencers (long and short pipeline) driven in lockstep against a pass-timing model.
module tb_tpu_run_sequencer;
    localparam int AW = 10, PA = 257, PB = 2, VW = 27;
    logic clk = 1'b0, rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, fifo_empty = 1'b1;
    logic [AW-1:0] num_rows = '0, ub_base = '0, res_base = '0;
    int total = 0, passed = 0;
    logic [VW-1:0] obs_a, obs_b, raw_a, raw_b;
    tpu_run_sequencer_if #(.ADDRESSSIZE(AW)) ia();
    tpu_run_sequencer_if #(.ADDRESSSIZE(AW)) ib();
    assign ia.start = start;
    assign ia.abort = abort;
    assign ia.fifo_empty = fifo_empty;
    assign ia.num_rows = num_rows;
    assign ia.ub_base = ub_base;
    assign ia.res_base = res_base;
    assign ib.start = start;
    assign ib.abort = abort;
    assign ib.fifo_empty = fifo_empty;
    assign ib.num_rows = num_rows;
    assign ib.ub_base = ub_base;
    assign ib.res_base = res_base;
    tpu_run_sequencer #(.ADDRESSSIZE(AW), .PIPE_LAT(PA), .CNT_W(12)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    tpu_run_sequencer #(.ADDRESSSIZE(AW), .PIPE_LAT(PB), .CNT_W(12)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    always #5 clk = ~clk;
    // Addresses only matter while their valid/strobe is high.
    assign obs_a = {ia.busy, ia.done, ia.err, ia.fifo_read_enable, ia.we_rl, ia.ub_valid,
                    ia.ub_valid ? ia.ub_address : {AW{1'b0}}, ia.res_write_enable,
                    ia.res_write_enable ? ia.res_address : {AW{1'b0}}};
    assign obs_b = {ib.busy, ib.done, ib.err, ib.fifo_read_enable, ib.we_rl, ib.ub_valid,
                    ib.ub_valid ? ib.ub_address : {AW{1'b0}}, ib.res_write_enable,
                    ib.res_write_enable ? ib.res_address : {AW{1'b0}}};
    assign raw_a = {ia.busy, ia.done, ia.err, ia.fifo_read_enable, ia.we_rl, ia.ub_valid,
                    ia.ub_address, ia.res_write_enable, ia.res_address};
    assign raw_b = {ib.busy, ib.done, ib.err, ib.fifo_read_enable, ib.we_rl, ib.ub_valid,
                    ib.ub_address, ib.res_write_enable, ib.res_address};
    // Expected outputs k cycles after start was sampled; w = extra cycles fifo stays empty,
    // ka = cycle in which abort is raised (0 = none).
    function automatic logic [VW-1:0] model(int p, int n, int ub, int rb, int w, int ka, int k);
        int j;
        logic bz, dn, er, fr, rl, uv, rw;
        logic [AW-1:0] ua, ra;
        j = k - (w + 4);
        if (ka > 0 && k > ka) return '0;
        er = n == 0 && k == 1;
        bz = n > 0 && k <= w + 4 + p + n;
        dn = n > 0 && j == p + n;
        fr = n > 0 && k == w + 2;
        rl = n > 0 && k == w + 3;
        uv = n > 0 && j >= 0 && j < n;
        rw = n > 0 && j >= p && j < p + n;
        ua = uv ? AW'(ub + j) : '0;
        ra = rw ? AW'(rb + j - p) : '0;
        return {bz, dn, er, fr, rl, uv, ua, rw, ra};
    endfunction
    task automatic chk(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    // sk = cycle with a stray start, aws = abort together with start, stop = early end cycle.
    task automatic run_pass(int n, int ub, int rb, int w, int ka, int sk, bit aws, int stop);
        int kend;
        kend = stop > 0 ? stop : (ka > 0 ? ka + 3 : w + 4 + PA + n + 2);
        start = 1'b1;
        abort = aws;
        num_rows = AW'(n);
        ub_base = AW'(ub);
        res_base = AW'(rb);
        fifo_empty = w > 0;
        for (int k = 1; k <= kend; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("a n=%0d k=%0d", n, k), obs_a, model(PA, n, ub, rb, w, ka, k));
            chk($sformatf("b n=%0d k=%0d", n, k), obs_b, model(PB, n, ub, rb, w, ka, k));
            start = k == sk;
            if (k == sk) begin
                num_rows = AW'($urandom);
                ub_base = AW'($urandom);
                res_base = AW'($urandom);
            end
            abort = k == ka;
            fifo_empty = k <= w;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask
    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset a", raw_a, '0);
        chk("reset b", raw_b, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_pass(4, 'h010, 'h020, 0, 0, 0, 1'b0, 0);
        run_pass(4, 'h100, 'h200, 10, 0, 0, 1'b0, 0);
        run_pass(3, 'h3FE, 'h3FF, 0, 0, 0, 1'b0, 0);
        run_pass(5, 'h040, 'h080, 1, 0, 0, 1'b0, 0);
        run_pass(0, 'h005, 'h005, 0, 0, 0, 1'b0, 4);
        run_pass(6, 'h0A0, 'h0B0, 2, 0, 7, 1'b0, 0);
        run_pass(4, 'h010, 'h020, 0, 104, 0, 1'b0, 0);
        run_pass(3, 'h001, 'h002, 0, 0, 0, 1'b1, 0);
        for (int i = 0; i < 3; i++)
            run_pass(int'($urandom_range(8, 1)), int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                     int'($urandom_range(4, 0)), 0, 0, 1'($urandom_range(1, 0)), 0);
        run_pass(4, 'h010, 'h020, 0, 0, 0, 1'b0, 4 + PA + 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst a", raw_a, '0);
        chk("async rst b", raw_b, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
